// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// data_mem_responder : handshaked load/store responder on a little-endian array
// Revision 1.0
// ============================================================================
module data_mem_responder #(
   parameter int DW      = 32,
   parameter int AW      = 16,
   parameter int LATENCY = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid_i,
   output logic          req_ready_o,
   input  logic          req_we_i,
   input  logic [DW-1:0] req_addr_i,
   input  logic [DW-1:0] req_wdata_i,
   input  logic [1:0]    req_type_i,
   input  logic          req_sign_i,
   output logic          resp_valid_o,
   input  logic          resp_ready_i,
   output logic [DW-1:0] resp_rdata_o,
   output logic          resp_err_o
);

   generate
      if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
         $error("data_mem_responder: LATENCY must be 0..15");
      end
      if (DW != 32 || AW >= DW || AW < 2) begin : g_bad_width
         $error("data_mem_responder: DW must be 32 and 2 <= AW < DW");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [1:0] TYPE_BYTE = 2'b00;
   localparam logic [1:0] TYPE_HALF = 2'b01;
   localparam logic [1:0] TYPE_WORD = 2'b10;

   state_t          state;
   logic [3:0]      cnt;
   logic            hold_we;
   logic [AW-1:0]   hold_addr;
   logic [DW-1:0]   hold_wdata;
   logic [1:0]      hold_type;
   logic            hold_sign;

   logic [7:0]      mem [0:(2**AW)-1];
   logic [7:0]      b0, b1, b2, b3;
   logic [DW-1:0]   load_data;
   logic            req_err;
   logic            access;
   logic            unused_addr_bits;

   assign unused_addr_bits = ^req_addr_i[DW-1:AW];

   assign req_ready_o = (state == IDLE);

   // The final WAIT cycle is the access edge, so a response appears
   // LATENCY+1 edges after acceptance.
   assign access = (state == WAIT) && (cnt == 4'd0);

   assign req_err = (hold_type == 2'b11)
                  | ((hold_type == TYPE_HALF) & hold_addr[0])
                  | ((hold_type == TYPE_WORD) & (hold_addr[1:0] != 2'b00));

   always_comb begin
      b0 = mem[hold_addr];
      b1 = mem[hold_addr + AW'(1)];
      b2 = mem[hold_addr + AW'(2)];
      b3 = mem[hold_addr + AW'(3)];
      case (hold_type)
         TYPE_BYTE: load_data = {{(DW-8){hold_sign & b0[7]}}, b0};
         TYPE_HALF: load_data = {{(DW-16){hold_sign & b1[7]}}, b1, b0};
         default:   load_data = {b3, b2, b1, b0};
      endcase
   end

   // Array is not reset; a reset coinciding with the access edge suppresses the write.
   always_ff @(posedge clk) begin
      if (access && !rst && hold_we && !req_err) begin
         case (hold_type)
            TYPE_BYTE: mem[hold_addr] <= hold_wdata[7:0];
            TYPE_HALF: begin
               mem[hold_addr]          <= hold_wdata[7:0];
               mem[hold_addr + AW'(1)] <= hold_wdata[15:8];
            end
            default: begin
               mem[hold_addr]          <= hold_wdata[7:0];
               mem[hold_addr + AW'(1)] <= hold_wdata[15:8];
               mem[hold_addr + AW'(2)] <= hold_wdata[23:16];
               mem[hold_addr + AW'(3)] <= hold_wdata[31:24];
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= 4'd0;
         hold_we      <= 1'b0;
         hold_addr    <= '0;
         hold_wdata   <= '0;
         hold_type    <= 2'b00;
         hold_sign    <= 1'b0;
         resp_valid_o <= 1'b0;
         resp_rdata_o <= '0;
         resp_err_o   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  hold_we    <= req_we_i;
                  hold_addr  <= req_addr_i[AW-1:0];
                  hold_wdata <= req_wdata_i;
                  hold_type  <= req_type_i;
                  hold_sign  <= req_sign_i;
                  cnt        <= 4'(LATENCY);
                  state      <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == 4'd0) begin
                  state        <= RESP;
                  resp_valid_o <= 1'b1;
                  resp_err_o   <= req_err;
                  resp_rdata_o <= (req_err || hold_we) ? '0 : load_data;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready_i) begin
                  state        <= IDLE;
                  resp_valid_o <= 1'b0;
                  resp_rdata_o <= '0;
                  resp_err_o   <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
